// File: rtl/udp_rx_checker.sv
// rtl/udp_rx_checker.sv - streaming UDP datagram header/length/checksum checker
//
// Accepts a UDP datagram (8-byte header + payload) as a valid/ready beat
// stream, extracts the header fields, accumulates the 16-bit ones'-complement
// checksum with end-around carry, counts bytes against the length field and
// reports one pass/fail verdict per datagram.
//
// Optional feature macro: UDP_PSEUDO_HDR_EN (adds src_ip/dst_ip and folds the
// IPv4 pseudo header into the checksum, giving the RFC 768 checksum).
//
// Parameters:
//   DATA_W     beat width in bits: 16, 32 or 64 (HDR_BEATS = 64/DATA_W)
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   in_data    beat data, byte k at in_data[DATA_W-1-8k -: 8]
//   in_keep    byte-valid mask, MSB-first like the data lanes: the mask bit
//              for byte k is in_keep[DATA_W/8-1-k] (0x80 on a 64-bit beat
//              is a lone byte 0). Full on non-last beats.
//   in_valid, in_last, in_ready   beat handshake
//   src_ip, dst_ip   (UDP_PSEUDO_HDR_EN only) pseudo header addresses
//   hdr_valid  one-cycle pulse when the header is complete
//   src_port, dst_port, udp_len, rx_csum   header fields, held
//   done       one-cycle verdict pulse; csum_ok/len_err held from done
//   busy       high whenever the FSM is not IDLE
module udp_rx_checker #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W/8-1:0] in_keep,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
`ifdef UDP_PSEUDO_HDR_EN
  input  logic [31:0]       src_ip,
  input  logic [31:0]       dst_ip,
`endif
  output logic              hdr_valid,
  output logic [15:0]       src_port,
  output logic [15:0]       dst_port,
  output logic [15:0]       udp_len,
  output logic [15:0]       rx_csum,
  output logic              done,
  output logic              csum_ok,
  output logic              len_err,
  output logic              busy
);

  localparam int HDR_BEATS = 64 / DATA_W;
  localparam int NB        = DATA_W / 8;
  localparam int NW        = DATA_W / 16;
  localparam int LSW       = 16 + $clog2(NW) + 1;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAYLOAD, S_FOLD, S_REPORT} state_t;

  state_t      state;
  logic [2:0]  hcnt;      // header beats already taken
  logic [16:0] acc;       // ones'-complement sum, bit 16 is a pending carry
  logic [15:0] bcnt;
  logic        runt;

  logic        accept, in_hdr, hdr_done_beat;
  logic [63:0] hdr_next;

  assign accept        = in_valid & in_ready;
  assign in_hdr        = (state == S_IDLE) || (state == S_HDR);
  assign hdr_done_beat = accept & in_hdr & (hcnt == 3'(HDR_BEATS - 1));

  // Header assembly: narrow beats are held until the final header beat, so
  // the field registers only ever see a complete header.
  generate
    if (DATA_W == 64) begin : g_hdr_wide
      assign hdr_next = in_data;
    end else begin : g_hdr_narrow
      logic [63-DATA_W:0] hold;
      assign hdr_next = {hold, in_data};
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hold <= '0;
        end else if (accept && in_hdr) begin
          hold <= hdr_next[63-DATA_W:0];
        end
      end
    end
  endgenerate

  // Per-beat lane sum; masked bytes contribute zero, so a lone trailing byte
  // naturally becomes {byte, 8'h00}.
  logic [LSW-1:0] lsum;
  logic [7:0]     b_hi, b_lo;
  always_comb begin
    lsum = '0;
    b_hi = 8'h00;
    b_lo = 8'h00;
    for (int j = 0; j < NW; j++) begin
      b_hi = in_keep[NB-1-2*j] ? in_data[DATA_W-1-16*j -: 8] : 8'h00;
      b_lo = in_keep[NB-2-2*j] ? in_data[DATA_W-9-16*j -: 8] : 8'h00;
      lsum = lsum + LSW'({b_hi, b_lo});
    end
  end

  logic [16:0] beat_fold;
  assign beat_fold = 17'(lsum[15:0]) + 17'(lsum[LSW-1:16]);

  logic [16:0] seed;
  logic [15:0] extra;
`ifdef UDP_PSEUDO_HDR_EN
  logic [18:0] seed_raw;
  assign seed_raw = 19'(src_ip[31:16]) + 19'(src_ip[15:0]) +
                    19'(dst_ip[31:16]) + 19'(dst_ip[15:0]) + 19'h00011;
  assign seed     = 17'(seed_raw[15:0]) + 17'(seed_raw[18:16]);
  // The pseudo header carries the UDP length a second time.
  assign extra    = hdr_done_beat ? hdr_next[31:16] : 16'h0000;
`else
  assign seed     = 17'd0;
  assign extra    = 16'h0000;
`endif

  // A new datagram starts from the seed, not from the stale accumulator.
  logic [16:0] acc_base, acc_next;
  logic [18:0] acc_sum;
  assign acc_base = (state == S_IDLE) ? seed : acc;
  assign acc_sum  = 19'(acc_base[15:0]) + 19'(acc_base[16]) +
                    19'(beat_fold) + 19'(extra);
  assign acc_next = 17'(acc_sum[15:0]) + 17'(acc_sum[18:16]);

  logic [3:0] kcnt;
  always_comb begin
    kcnt = 4'd0;
    for (int i = 0; i < NB; i++) begin
      kcnt = kcnt + 4'(in_keep[i]);
    end
  end

  logic [16:0] bsum;
  logic [15:0] bcnt_next;
  assign bsum      = 17'((state == S_IDLE) ? 16'h0000 : bcnt) + 17'(kcnt);
  assign bcnt_next = bsum[16] ? 16'hFFFF : bsum[15:0];

  // After a per-beat fold a set bit 16 implies tiny low bits, so one more
  // end-around add lands in 16 bits.
  logic [15:0] fin_sum;
  logic        len_err_n, csum_ok_n;
  assign fin_sum   = acc[15:0] + 16'(acc[16]);
  assign len_err_n = (bcnt != udp_len) || (udp_len < 16'd8) || runt;
  assign csum_ok_n = !len_err_n && ((rx_csum == 16'h0000) || (fin_sum == 16'hFFFF));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      hcnt      <= 3'd0;
      acc       <= 17'd0;
      bcnt      <= 16'h0000;
      runt      <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      hdr_valid <= 1'b0;
      src_port  <= 16'h0000;
      dst_port  <= 16'h0000;
      udp_len   <= 16'h0000;
      rx_csum   <= 16'h0000;
      done      <= 1'b0;
      csum_ok   <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      hdr_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE, S_HDR: begin
          in_ready <= 1'b1;
          if (accept) begin
            acc  <= acc_next;
            bcnt <= bcnt_next;
            busy <= 1'b1;
            if (hdr_done_beat) begin
              hdr_valid <= 1'b1;
              src_port  <= hdr_next[63:48];
              dst_port  <= hdr_next[47:32];
              udp_len   <= hdr_next[31:16];
              rx_csum   <= hdr_next[15:0];
              hcnt      <= 3'd0;
              if (in_last) begin
                state    <= S_FOLD;
                in_ready <= 1'b0;
              end else begin
                state <= S_PAYLOAD;
              end
            end else if (in_last) begin
              runt     <= 1'b1;
              hcnt     <= 3'd0;
              state    <= S_FOLD;
              in_ready <= 1'b0;
            end else begin
              hcnt  <= hcnt + 3'd1;
              state <= S_HDR;
            end
          end
        end
        S_PAYLOAD: begin
          if (accept) begin
            acc  <= acc_next;
            bcnt <= bcnt_next;
            if (in_last) begin
              state    <= S_FOLD;
              in_ready <= 1'b0;
            end
          end
        end
        S_FOLD: begin
          csum_ok <= csum_ok_n;
          len_err <= len_err_n;
          done    <= 1'b1;
          state   <= S_REPORT;
        end
        S_REPORT: begin
          acc      <= 17'd0;
          bcnt     <= 16'h0000;
          runt     <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_rx_checker.sv
// tb/tb_udp_rx_checker.sv - self-checking bench for udp_rx_checker (64- and 32-bit beats)
module tb_udp_rx_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 64-bit instance
  logic [63:0] d64;  logic [7:0] k64;  logic v64, l64, r64, hv64, done64, ok64, le64, busy64;
  logic [15:0] sp64, dp64, ul64, rc64;
  // 32-bit instance
  logic [31:0] d32;  logic [3:0] k32;  logic v32, l32, r32, hv32, done32, ok32, le32, busy32;
  logic [15:0] sp32, dp32, ul32, rc32;

  udp_rx_checker #(.DATA_W(64)) dut64 (
    .clk(clk), .rst(rst), .in_data(d64), .in_keep(k64), .in_valid(v64), .in_last(l64),
    .in_ready(r64), .hdr_valid(hv64), .src_port(sp64), .dst_port(dp64), .udp_len(ul64),
    .rx_csum(rc64), .done(done64), .csum_ok(ok64), .len_err(le64), .busy(busy64));

  udp_rx_checker #(.DATA_W(32)) dut32 (
    .clk(clk), .rst(rst), .in_data(d32), .in_keep(k32), .in_valid(v32), .in_last(l32),
    .in_ready(r32), .hdr_valid(hv32), .src_port(sp32), .dst_port(dp32), .udp_len(ul32),
    .rx_csum(rc32), .done(done32), .csum_ok(ok32), .len_err(le32), .busy(busy32));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", nm);
  endtask

  typedef struct { logic [15:0] s, d, l, c; } hdr_t;
  typedef struct { bit ok; bit lerr; } res_t;
  typedef struct { logic [63:0] b0; logic [63:0] b1; int n1; bit ok; bit lerr; } vec_t;

  hdr_t hq64[$], hq32[$];
  res_t rq64[$], rq32[$];
  hdr_t hm64, hm32;
  res_t rm64, rm32;
  int hdr_cyc[2];
  int last_cyc[2];
  logic [7:0] pkt[$];

  // Scoreboard side: pop and compare whenever a DUT reports.
  always @(negedge clk) begin
    if (hv64) begin
      if (hq64.size() == 0) fail_now("hdr64_unexpected");
      else begin
        hm64 = hq64.pop_front();
        chk("hdr64_src", 32'(sp64), 32'(hm64.s));
        chk("hdr64_dst", 32'(dp64), 32'(hm64.d));
        chk("hdr64_len", 32'(ul64), 32'(hm64.l));
        chk("hdr64_csum", 32'(rc64), 32'(hm64.c));
        chk("hdr64_cycle", cyc, hdr_cyc[0]);
      end
    end
    if (done64) begin
      if (rq64.size() == 0) fail_now("done64_unexpected");
      else begin
        rm64 = rq64.pop_front();
        chk("res64_csum_ok", 32'(ok64), 32'(rm64.ok));
        chk("res64_len_err", 32'(le64), 32'(rm64.lerr));
        chk("res64_done_cycle", cyc, last_cyc[0] + 1);
      end
    end
    if (hv32) begin
      if (hq32.size() == 0) fail_now("hdr32_unexpected");
      else begin
        hm32 = hq32.pop_front();
        chk("hdr32_src", 32'(sp32), 32'(hm32.s));
        chk("hdr32_dst", 32'(dp32), 32'(hm32.d));
        chk("hdr32_len", 32'(ul32), 32'(hm32.l));
        chk("hdr32_csum", 32'(rc32), 32'(hm32.c));
        chk("hdr32_cycle", cyc, hdr_cyc[1]);
      end
    end
    if (done32) begin
      if (rq32.size() == 0) fail_now("done32_unexpected");
      else begin
        rm32 = rq32.pop_front();
        chk("res32_csum_ok", 32'(ok32), 32'(rm32.ok));
        chk("res32_len_err", 32'(le32), 32'(rm32.lerr));
        chk("res32_done_cycle", cyc, last_cyc[1] + 1);
      end
    end
  end

  task automatic push_exp(input int which, input bit ok, input bit lerr, input bit has_hdr);
    hdr_t h;
    res_t r;
    h.s = {pkt[0], pkt[1]};
    h.d = {pkt[2], pkt[3]};
    h.l = {pkt[4], pkt[5]};
    h.c = {pkt[6], pkt[7]};
    r.ok = ok;
    r.lerr = lerr;
    if (which == 0) begin
      if (has_hdr) hq64.push_back(h);
      rq64.push_back(r);
    end else begin
      if (has_hdr) hq32.push_back(h);
      rq32.push_back(r);
    end
  endtask

  // Ones'-complement sum of the whole packet, accumulated wide and folded at the end.
  function automatic logic [15:0] model_sum();
    logic [31:0] s;
    s = 0;
    for (int i = 0; i < pkt.size(); i += 2)
      s += {16'h0000, pkt[i], (i + 1 < pkt.size()) ? pkt[i+1] : 8'h00};
    while (s[31:16] != 0) s = {16'h0000, s[15:0]} + {16'h0000, s[31:16]};
    return s[15:0];
  endfunction

  task automatic drive_beat(input int which, input logic [63:0] d, input logic [7:0] k,
                            input bit last, input bit gap, output int ac);
    bit got;
    bit rdy;
    if (gap) begin
      // Idle cycle with junk on the qualifiers, which must be ignored.
      v64 = 1'b0; v32 = 1'b0;
      l64 = 1'b1; l32 = 1'b1;
      d64 = 64'($urandom); d32 = $urandom;
      @(posedge clk); #1;
    end
    if (which == 0) begin d64 = d; k64 = k; l64 = last; v64 = 1'b1; end
    else begin d32 = d[63:32]; k32 = k[7:4]; l32 = last; v32 = 1'b1; end
    got = 1'b0;
    for (int n = 0; n < 64 && !got; n++) begin
      @(negedge clk);
      rdy = (which == 0) ? r64 : r32;
      @(posedge clk); #1;
      got = rdy;
    end
    if (!got) fail_now("accept_timeout");
    ac = cyc;
    v64 = 1'b0; v32 = 1'b0;
  endtask

  task automatic send_pkt(input int which, input bit gap);
    int nb, hb, n, nbeats, ac;
    nb = (which == 0) ? 8 : 4;
    hb = (which == 0) ? 1 : 2;
    n = pkt.size();
    nbeats = (n + nb - 1) / nb;
    for (int i = 0; i < nbeats; i++) begin
      logic [63:0] d;
      logic [7:0] k;
      int cnt;
      d = 64'($urandom);
      d = {d[31:0], 32'($urandom)};
      cnt = 0;
      for (int j = 0; j < nb; j++)
        if (i * nb + j < n) begin
          d[63-8*j -: 8] = pkt[i*nb+j];
          cnt++;
        end
      k = 8'hFF << (8 - cnt);
      drive_beat(which, d, k, i == nbeats - 1, gap, ac);
      if (i == hb - 1) hdr_cyc[which] = ac;
      if (i == nbeats - 1) last_cyc[which] = ac;
    end
  endtask

  task automatic load_vec(input vec_t v);
    logic [63:0] b;
    pkt.delete();
    b = v.b0;
    for (int j = 0; j < 8; j++) pkt.push_back(b[63-8*j -: 8]);
    b = v.b1;
    for (int j = 0; j < v.n1; j++) pkt.push_back(b[63-8*j -: 8]);
  endtask

  vec_t vt[8];

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{64'h1234_5678_000C_F9A9, 64'hDEAD_BEEF_0000_0000, 4, 1'b1, 1'b0};
    vt[1] = '{64'h1234_5678_000C_F9A8, 64'hDEAD_BEEF_0000_0000, 4, 1'b0, 1'b0};
    vt[2] = '{64'h1234_5678_000C_0000, 64'hDEAD_BEEF_0000_0000, 4, 1'b1, 1'b0};
    vt[3] = '{64'h1234_5678_0009_EC49, 64'hAB00_0000_0000_0000, 1, 1'b1, 1'b0};
    vt[4] = '{64'h1234_5678_0010_F9A9, 64'hDEAD_BEEF_0000_0000, 4, 1'b0, 1'b1};
    vt[5] = '{64'h1234_5678_0008_974B, 64'h0, 0, 1'b1, 1'b0};
    vt[6] = '{64'h1234_5678_0008_F9A9, 64'hDEAD_BEEF_0000_0000, 4, 1'b0, 1'b1};
    vt[7] = '{64'h1234_5678_0004_0000, 64'h0, 0, 1'b0, 1'b1};

    d64 = '0; k64 = '0; v64 = 1'b0; l64 = 1'b0;
    d32 = '0; k32 = '0; v32 = 1'b0; l32 = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready64", 32'(r64), 0);
    chk("rst_in_ready32", 32'(r32), 0);
    chk("rst_hdr_valid", 32'(hv64), 0);
    chk("rst_fields", {sp64, dp64} | {ul64, rc64}, 0);
    chk("rst_done", 32'(done64), 0);
    chk("rst_verdict", {30'd0, ok64, le64}, 0);
    chk("rst_busy", 32'(busy64), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready64", 32'(r64), 1);
    chk("post_rst_in_ready32", 32'(r32), 1);

    // Table-driven 64-bit datagrams
    for (int i = 0; i < 8; i++) begin
      load_vec(vt[i]);
      push_exp(0, vt[i].ok, vt[i].lerr, 1'b1);
      send_pkt(0, 1'b0);
      if (i == 0) begin
        // Two-cycle bubble: FOLD and REPORT refuse beats.
        @(negedge clk);
        chk("bubble_fold_ready", 32'(r64), 0);
        chk("bubble_fold_busy", 32'(busy64), 1);
        @(negedge clk);
        chk("bubble_report_ready", 32'(r64), 0);
        @(negedge clk);
        chk("bubble_idle_ready", 32'(r64), 1);
        chk("bubble_idle_busy", 32'(busy64), 0);
        @(posedge clk); #1;
      end
    end

    // in_valid toggling every cycle
    load_vec(vt[0]);
    push_exp(0, 1'b1, 1'b0, 1'b1);
    send_pkt(0, 1'b1);

    // Reset between beats aborts the datagram
    begin
      int ac;
      load_vec(vt[0]);
      push_exp(0, 1'b1, 1'b0, 1'b1);
      void'(rq64.pop_back());
      drive_beat(0, vt[0].b0, 8'hFF, 1'b0, 1'b0, ac);
      hdr_cyc[0] = ac;
      @(posedge clk); #1;
      chk("abort_busy_before", 32'(busy64), 1);
      rst = 1'b1;
      #1;
      chk("abort_busy_in_rst", 32'(busy64), 0);
      chk("abort_ready_in_rst", 32'(r64), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("abort_ready_after", 32'(r64), 1);
    end
    load_vec(vt[0]);
    push_exp(0, 1'b1, 1'b0, 1'b1);
    send_pkt(0, 1'b0);

    // Random datagrams on both widths, some with a corrupted byte
    for (int r = 0; r < 8; r++) begin
      int n, w;
      logic [15:0] c;
      bit ok;
      w = r % 2;
      n = $urandom_range(9, 40);
      pkt.delete();
      for (int j = 0; j < n; j++) pkt.push_back(8'($urandom));
      pkt[4] = 8'(n >> 8);
      pkt[5] = 8'(n);
      pkt[6] = 8'h00;
      pkt[7] = 8'h00;
      c = ~model_sum();
      pkt[6] = c[15:8];
      pkt[7] = c[7:0];
      if (r >= 4) pkt[8] = pkt[8] ^ 8'h5A;
      ok = ({pkt[6], pkt[7]} == 16'h0000) || (model_sum() == 16'hFFFF);
      push_exp(w, ok, 1'b0, 1'b1);
      send_pkt(w, r[1]);
    end

    // 32-bit: clean datagram over HDR_BEATS=2, then a one-beat runt
    load_vec(vt[0]);
    push_exp(1, 1'b1, 1'b0, 1'b1);
    send_pkt(1, 1'b0);
    pkt.delete();
    pkt.push_back(8'h12); pkt.push_back(8'h34); pkt.push_back(8'h56); pkt.push_back(8'h78);
    begin
      res_t rr;
      rr.ok = 1'b0;
      rr.lerr = 1'b1;
      rq32.push_back(rr);
    end
    send_pkt(1, 1'b0);

    repeat (10) @(posedge clk);
    #1;
    chk("left_hdr64", hq64.size(), 0);
    chk("left_res64", rq64.size(), 0);
    chk("left_hdr32", hq32.size(), 0);
    chk("left_res32", rq32.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
